spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI mode-0 slave that is the downstream consumer of simple_spi's serial output.
//  Oversamples sclk/cs_n/mosi in the system clock domain and deserializes DATA_W-bit words.
//  Presents each word on a valid/ready port and shifts a reply word out on miso.
//  Used as the loopback/receive end when the master is exercised on-chip.
// PARAMETERS
//  DATA_W       8   bits per word
//  SYNC_STAGES  2   synchronizer flops per serial input (>=2)
//  MSB_FIRST    1   1: MSB shifted first on mosi and miso; 0: LSB first
// PORTS
//  clk       in   1       system clock; must run >= 4x sclk
//  rst       in   1       synchronous reset, active-high
//  sclk      in   1       SPI clock from master; idle low
//  cs_n      in   1       chip select, active low
//  mosi      in   1       serial data from master
//  miso      out  1       serial reply data; driven 0 when deselected (no tristate)
//  tx_data   in   DATA_W  reply word; captured at frame start and at each word boundary
//  rx_data   out  DATA_W  received word
//  rx_valid  out  1       rx_data holds an unconsumed word
//  rx_ready  in   1       consumer accepts rx_data when rx_valid & rx_ready
//  overrun   out  1       1-cycle pulse: word completed while buffer full; new word dropped
//  frame_err out  1       1-cycle pulse: cs_n rose with a partial word; partial word discarded
// BEHAVIOUR
//  Reset: miso=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0; state=IDLE, bit_cnt=0.
//   All sync flops reset to idle levels: sclk=0, cs_n=1, mosi=0.
//  Sync: each input passes SYNC_STAGES flops; edges = synced value vs one further flop.
//   Edge-detect latency is SYNC_STAGES+1 clk.
//  FSM states: IDLE, ACTIVE.
//   IDLE->ACTIVE on cs_n fall: bit_cnt=0; tx_shift<=tx_data; miso<=first reply bit.
//   ACTIVE, sclk rise: shift synced mosi into rx_shift; bit_cnt++.
//   ACTIVE, sclk fall: advance tx_shift; miso<=next bit.
//   Word complete (sclk rise with bit_cnt==DATA_W-1): bit_cnt wraps to 0.
//    tx_shift<=tx_data, so multi-word frames are supported.
//    Buffer free (rx_valid=0, or rx_valid&rx_ready this cycle): rx_data<=word, rx_valid<=1 next clk.
//    Buffer full: rx_data unchanged; overrun pulses next clk.
//   ACTIVE->IDLE on cs_n rise: frame_err pulses if bit_cnt!=0; rx_shift/bit_cnt cleared; miso<=0.
//  rx_valid clears on handshake unless a new word loads in the same cycle; then it stays 1.
//  Simultaneous sclk rise + cs_n rise: the sample is processed first, then cs_n is evaluated.
//   A word completed by that final edge is delivered and does not raise frame_err.
//  sclk edges while IDLE are ignored.
//  cs_n fall while ACTIVE cannot occur; no special handling.
//  Reset mid-frame: immediate return to reset values; partial word lost; no error pulse.
//  rx_valid/rx_data are independent of cs_n: a word stays valid after frame end until consumed.
// STRUCTURE
//  spi_pkg: state enum (SPI_IDLE, SPI_ACTIVE), SPI_MODE0 constant, default DATA_W localparam.
//  Sub-module spi_sync_edge (SYNC_STAGES, RST_VAL): synchronizer plus rise/fall pulse outputs.
//   Instantiated 3x: sclk, cs_n, mosi (mosi uses level only).
//  Top holds FSM, bit counter, rx/tx shift registers and 1-entry output buffer.
// TESTING
//  1 Frame 0xA5, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5; no overrun/frame_err.
//  2 tx_data=0x3C, master sends 0x00 -> master captures 0x3C on miso; miso=0 after cs_n rises.
//  3 3-word frame 0x11,0x22,0x33, rx_ready=0 until frame end
//    -> rx_data=0x11 held; overrun pulses twice; after handshake rx_valid=0.
//  4 cs_n rises after 5 bits -> frame_err single pulse, no rx_valid.
//    Next full frame 0x5A received correctly.
//  5 rst asserted mid-word -> all outputs at reset values next clk.
//    Subsequent frame 0xFF received.
//  6 MSB_FIRST=0, frame bits 1,0,0,0,0,0,0,0 -> rx_data=0x01.
//    Pop coinciding with next word load keeps rx_valid=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive slice.
// No logic; types and constants only.
// Not applicable: no datapath here.
package spi_pkg;

  // FSM encoding for the slave frame tracker
  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  // {CPOL, CPHA}; mode 0 idles sclk low and samples on the rising edge
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Default word width
  localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async input with rise/fall pulse outputs.
// Level is SYNC_STAGES clk late; rise/fall pulses are combinational off the last two flops.
// No backpressure: free-running, samples every clk.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Next-state: shift the raw input into the chain, keep one extra flop for edges
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Chain registers reset to the line's idle level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled deserializer with a 1-entry valid/ready output and miso reply.
// Edge-to-action latency SYNC_STAGES+1 clk; a completed word is visible on rx_data the clk after.
// Holds one word; a word completing while it is still unconsumed is dropped and flagged by overrun.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_MODE0[1])) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] rx_word;
  logic              pop;

  assign rx_word = rx_ins(rx_shift_q, mosi_s);
  assign pop     = rx_valid_q & rx_ready;

  // Frame FSM, shift registers and output buffer next-state.
  // tx_shift holds reply bits not yet placed on miso: the head bit goes out at
  // frame start or on each sclk fall, so a word-boundary reload is output intact.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~pop;
    miso_d      = miso_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_d    = SPI_ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_adv(tx_data);
          miso_d     = head_bit(tx_data);
        end
      end
      SPI_ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            tx_shift_d = tx_data;
            if (!rx_valid_q || pop) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          miso_d     = head_bit(tx_shift_q);
          tx_shift_d = tx_adv(tx_shift_q);
        end
        // cs_n is evaluated after any same-cycle sample so a final-edge word counts
        if (cs_rise) begin
          state_d     = SPI_IDLE;
          frame_err_d = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          miso_d      = 1'b0;
        end
      end
      default: state_d = SPI_IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial word silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SPI_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench: MSB-first and LSB-first slaves share one SPI master and consumer.
// Master drives sclk at 1/12 of clk; consumer pops on rx_ready.
// Expected words/replies come from a transaction-level model of the frames sent.
module tb_spi_slave_rx;

  localparam int HALF = 6;

  logic       clk, rst, sclk, cs_n, mosi, rx_ready;
  logic [7:0] tx_data;
  logic       miso_m, rx_valid_m, overrun_m, frame_err_m;
  logic       miso_l, rx_valid_l, overrun_l, frame_err_l;
  logic [7:0] rx_data_m, rx_data_l;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso_m),
    .tx_data(tx_data), .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_ready(rx_ready),
    .overrun(overrun_m), .frame_err(frame_err_m)
  );

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso_l),
    .tx_data(tx_data), .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready),
    .overrun(overrun_l), .frame_err(frame_err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fw[4];
  logic [7:0] ft[4];
  logic [7:0] got_m[$], got_l[$], rep_m[$], rep_l[$];
  int ovr_m, ovr_l, ferr_m, ferr_l;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_m.delete(); got_l.delete(); rep_m.delete(); rep_l.delete();
    ovr_m = 0; ovr_l = 0; ferr_m = 0; ferr_l = 0;
  endtask

  // Consumer/pulse monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid_m && rx_ready) got_m.push_back(rx_data_m);
      if (rx_valid_l && rx_ready) got_l.push_back(rx_data_l);
      ovr_m  = ovr_m + int'(overrun_m);
      ovr_l  = ovr_l + int'(overrun_l);
      ferr_m = ferr_m + int'(frame_err_m);
      ferr_l = ferr_l + int'(frame_err_l);
    end
  end

  // Master: n words from fw[], reply words expected from ft[], MSB first on the wire
  task automatic send(input int n, input bit simul, input bit coinc);
    logic [7:0] cm, cl;
    cm = '0; cl = '0;
    tx_data = ft[0];
    tick(1);
    cs_n = 1'b0;
    tick(HALF);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 1 && k + 1 < n) tx_data = ft[k+1];
        mosi = fw[k][7-i];
        tick(HALF);
        cm = {cm[6:0], miso_m};
        cl = {cl[6:0], miso_l};
        sclk = 1'b1;
        if (k == n - 1 && i == 7 && simul) cs_n = 1'b1;
        if (k == n - 1 && i == 7 && coinc) begin
          tick(2);
          rx_ready = 1'b1;
          tick(1);
          rx_ready = 1'b0;
          chk("coinc valid_m", rx_valid_m, 1);
          chk("coinc valid_l", rx_valid_l, 1);
          chk("coinc data_m", rx_data_m, fw[k]);
          chk("coinc data_l", rx_data_l, rev8(fw[k]));
          tick(HALF - 3);
        end else begin
          tick(HALF);
        end
        sclk = 1'b0;
        if (i == 7) begin
          rep_m.push_back(cm);
          rep_l.push_back(cl);
        end
      end
    end
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    chk("idle miso_m", miso_m, 0);
    chk("idle miso_l", miso_l, 0);
  endtask

  // One complete frame plus checks; mode 1 = consumer always ready, 0 = drain after frame
  task automatic run_frame(input string tag, input int n, input bit mode, input bit simul,
                           input bit coinc);
    int ne;
    clear_obs();
    rx_ready = mode;
    send(n, simul, coinc);
    if (!mode) begin
      if (!coinc) begin
        chk({tag, " held_m"}, rx_data_m, fw[0]);
        chk({tag, " held_l"}, rx_data_l, rev8(fw[0]));
      end
      rx_ready = 1'b1;
      tick(3);
      rx_ready = 1'b0;
      tick(1);
    end
    chk({tag, " empty_m"}, rx_valid_m, 0);
    chk({tag, " empty_l"}, rx_valid_l, 0);
    ne = (mode || coinc) ? n : 1;
    chk({tag, " nwords_m"}, got_m.size(), ne);
    chk({tag, " nwords_l"}, got_l.size(), ne);
    for (int i = 0; i < ne && i < got_m.size(); i++) chk({tag, " word_m"}, got_m[i], fw[i]);
    for (int i = 0; i < ne && i < got_l.size(); i++) chk({tag, " word_l"}, got_l[i], rev8(fw[i]));
    chk({tag, " overrun_m"}, ovr_m, (mode || coinc) ? 0 : n - 1);
    chk({tag, " overrun_l"}, ovr_l, (mode || coinc) ? 0 : n - 1);
    chk({tag, " ferr_m"}, ferr_m, 0);
    chk({tag, " ferr_l"}, ferr_l, 0);
    for (int i = 0; i < n; i++) begin
      chk({tag, " reply_m"}, rep_m[i], ft[i]);
      chk({tag, " reply_l"}, rep_l[i], rev8(ft[i]));
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; rx_ready = 1'b0;
    clear_obs();
    tick(3);
    chk("rst rx_valid", rx_valid_m | rx_valid_l, 0);
    chk("rst rx_data_m", rx_data_m, 0);
    chk("rst rx_data_l", rx_data_l, 0);
    chk("rst miso", {miso_m, miso_l}, 0);
    chk("rst pulses", {overrun_m, overrun_l, frame_err_m, frame_err_l}, 0);
    rst = 1'b0;
    tick(3);

    // Single word, always-ready consumer
    fw[0] = 8'hA5; ft[0] = 8'h00;
    run_frame("t1", 1, 1'b1, 1'b0, 1'b0);

    // Reply path while master sends zeros
    fw[0] = 8'h00; ft[0] = 8'h3C;
    run_frame("t2", 1, 1'b1, 1'b0, 1'b0);

    // Three words into a full buffer
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
    ft[0] = 8'h81; ft[1] = 8'h42; ft[2] = 8'hE7;
    run_frame("t3", 3, 1'b0, 1'b0, 1'b0);

    // Frame aborted after 5 bits
    clear_obs();
    rx_ready = 1'b1;
    cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    cs_n = 1'b1;
    tick(8);
    chk("t4 ferr_m", ferr_m, 1);
    chk("t4 ferr_l", ferr_l, 1);
    chk("t4 nwords", got_m.size() + got_l.size(), 0);
    chk("t4 valid", rx_valid_m | rx_valid_l, 0);
    chk("t4 overrun", ovr_m + ovr_l, 0);
    fw[0] = 8'h5A; ft[0] = 8'hC6;
    run_frame("t4b", 1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a word, with a buffered word pending
    clear_obs();
    rx_ready = 1'b0;
    fw[0] = 8'h77; ft[0] = 8'h00;
    send(1, 1'b0, 1'b0);
    chk("t5 preload valid", rx_valid_m & rx_valid_l, 1);
    tx_data = 8'hFF;
    tick(1);
    cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      if (i < 3) sclk = 1'b0;
    end
    chk("t5 pre-rst miso_m", miso_m, 1);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0;
    tick(1);
    chk("t5 rx_valid", {rx_valid_m, rx_valid_l}, 0);
    chk("t5 rx_data", {rx_data_m, rx_data_l}, 0);
    chk("t5 miso", {miso_m, miso_l}, 0);
    chk("t5 pulses", {overrun_m, overrun_l, frame_err_m, frame_err_l}, 0);
    rst = 1'b0;
    tick(6);
    chk("t5 no ferr", ferr_m + ferr_l, 0);
    fw[0] = 8'hFF; ft[0] = 8'h5B;
    run_frame("t5b", 1, 1'b1, 1'b0, 1'b0);

    // Bit order: wire bits 1,0,0,0,0,0,0,0 -> LSB-first slave sees 0x01
    fw[0] = 8'h80; ft[0] = 8'h01;
    run_frame("t6", 1, 1'b1, 1'b0, 1'b0);

    // Pop coinciding with the next word load
    fw[0] = 8'hC3; fw[1] = 8'h96; ft[0] = 8'h2D; ft[1] = 8'hB4;
    run_frame("t6b", 2, 1'b0, 1'b0, 1'b1);

    // Final sclk rise together with cs_n rise
    fw[0] = 8'h3E; ft[0] = 8'h71;
    run_frame("simul", 1, 1'b1, 1'b1, 1'b0);

    // Randomized frames
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        fw[k] = 8'($urandom);
        ft[k] = 8'($urandom);
      end
      run_frame("rnd", n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
